// File: rtl/smash_input_conditioner_pkg.sv
// Shared zone codes, handshake state encodings and defaults for the smash button front end.
package smash_input_conditioner_pkg;

  localparam int DEF_DEBOUNCE_TICKS = 500;

  typedef enum logic [1:0] {
    ZONE_TL = 2'd0,
    ZONE_TR = 2'd1,
    ZONE_BL = 2'd2,
    ZONE_BR = 2'd3
  } zone_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PEND     = 2'd1,
    WAIT_LOW = 2'd2
  } hs_state_e;

  // Lowest index wins when several buttons fire together.
  function automatic zone_e prio_zone(input logic [3:0] edges);
    if (edges[0])      return ZONE_TL;
    else if (edges[1]) return ZONE_TR;
    else if (edges[2]) return ZONE_BL;
    else               return ZONE_BR;
  endfunction

endpackage

// File: rtl/smash_input_conditioner_btn_debounce.sv
// One button: 2-flop synchroniser, debounce counter, debounced level and press pulse.
module btn_debounce
  import smash_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int CNT_W          = 10
) (
  input  logic clk100k,
  input  logic reset,
  input  logic btn_n,
  output logic btn_level,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_TICKS - 1);

  logic             sync1;
  logic             sync2;
  logic             pressed_s;
  logic [CNT_W-1:0] cnt;

  assign pressed_s = ~sync2;

  always_ff @(posedge clk100k) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  // rise is registered so it coincides with the first cycle of btn_level high.
  always_ff @(posedge clk100k) begin
    if (reset) begin
      cnt       <= '0;
      btn_level <= 1'b0;
      rise      <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (pressed_s == btn_level) begin
        cnt <= '0;
      end else if (cnt == CNT_TC) begin
        cnt       <= '0;
        btn_level <= pressed_s;
        rise      <= pressed_s;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/smash_input_conditioner.sv
// Debounces four smash buttons, priority-encodes press edges and hands one zone
// event at a time to the slow game domain over a 4-phase req/ack handshake.
//
// state    | meaning
// IDLE     | no event outstanding; accepts a press edge when ack_s is low
// PEND     | evt_valid high, zone/multi held until ack_s rises
// WAIT_LOW | request withdrawn, waiting for ack_s to return low
module smash_input_conditioner
  import smash_input_conditioner_pkg::*;
#(
  parameter int NUM_BTN        = 4,
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int CNT_W          = 10
) (
  input  logic               clk100k,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_n,
  input  logic               evt_ack,
  output logic               evt_valid,
  output logic [1:0]         evt_zone,
  output logic               evt_multi,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [3:0]         drop_count
);

  logic [NUM_BTN-1:0] rise;
  logic               ack1;
  logic               ack_s;
  hs_state_e          state_q;
  hs_state_e          state_d;
  logic               load;
  logic               drop;
  zone_e              zone_q;
  logic               multi_q;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
      .CNT_W         (CNT_W)
    ) u_deb (
      .clk100k  (clk100k),
      .reset    (reset),
      .btn_n    (btn_n[i]),
      .btn_level(btn_level[i]),
      .rise     (rise[i])
    );
  end

  always_ff @(posedge clk100k) begin
    if (reset) begin
      ack1  <= 1'b0;
      ack_s <= 1'b0;
    end else begin
      ack1  <= evt_ack;
      ack_s <= ack1;
    end
  end

  always_ff @(posedge clk100k) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A stuck-high ack in IDLE blocks new events; those presses count as drops.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    drop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|rise) begin
          if (ack_s) begin
            drop = 1'b1;
          end else begin
            load    = 1'b1;
            state_d = PEND;
          end
        end
      end
      PEND: begin
        drop = |rise;
        if (ack_s) state_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        drop = |rise;
        if (!ack_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk100k) begin
    if (reset) begin
      zone_q  <= ZONE_TL;
      multi_q <= 1'b0;
    end else if (load) begin
      zone_q  <= prio_zone(rise);
      multi_q <= (rise & (rise - 1'b1)) != '0;
    end
  end

  always_ff @(posedge clk100k) begin
    if (reset)                           drop_count <= '0;
    else if (drop && drop_count != 4'hF) drop_count <= drop_count + 4'd1;
  end

  assign evt_valid = (state_q == PEND);
  assign evt_zone  = zone_q;
  assign evt_multi = multi_q;

endmodule

// File: tb/tb_smash_input_conditioner.sv
// Directed bench for smash_input_conditioner with an 8-tick debounce window.
module tb_smash_input_conditioner;

  logic       clk100k = 1'b0;
  logic       reset;
  logic [3:0] btn_n;
  logic       evt_ack;
  logic       evt_valid;
  logic [1:0] evt_zone;
  logic       evt_multi;
  logic [3:0] btn_level;
  logic [3:0] drop_count;

  int n_cmp = 0;
  int n_err = 0;

  smash_input_conditioner #(
    .NUM_BTN       (4),
    .DEBOUNCE_TICKS(8),
    .CNT_W         (4)
  ) dut (
    .clk100k   (clk100k),
    .reset     (reset),
    .btn_n     (btn_n),
    .evt_ack   (evt_ack),
    .evt_valid (evt_valid),
    .evt_zone  (evt_zone),
    .evt_multi (evt_multi),
    .btn_level (btn_level),
    .drop_count(drop_count)
  );

  always #5 clk100k = ~clk100k;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk100k);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Raise ack, wait (bounded) for the request to drop, then complete the 4-phase cycle.
  task automatic handshake(input string tag);
    evt_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!evt_valid) break;
      tick(1);
    end
    chk(tag, 8'(evt_valid), 8'h0);
    evt_ack = 1'b0;
    tick(4);
  endtask

  initial begin
    reset   = 1'b1;
    btn_n   = 4'hF;
    evt_ack = 1'b0;
    tick(3);
    chk("rst_valid", 8'(evt_valid), 8'h0);
    chk("rst_zone",  8'(evt_zone),  8'h0);
    chk("rst_multi", 8'(evt_multi), 8'h0);
    chk("rst_level", 8'(btn_level), 8'h0);
    chk("rst_drop",  8'(drop_count), 8'h0);
    reset = 1'b0;

    // Clean press on BL: event exactly 11 edges after the raw change.
    btn_n = 4'b1011;
    tick(10);
    chk("clean_early", 8'(evt_valid), 8'h0);
    tick(1);
    chk("clean_valid", 8'(evt_valid), 8'h1);
    chk("clean_zone",  8'(evt_zone),  8'h2);
    chk("clean_multi", 8'(evt_multi), 8'h0);
    chk("clean_level", 8'(btn_level), 8'h4);
    tick(3);
    evt_ack = 1'b1;
    tick(2);
    chk("ack_hold", 8'(evt_valid), 8'h1);
    tick(1);
    chk("ack_drop", 8'(evt_valid), 8'h0);
    evt_ack = 1'b0;
    tick(3);
    tick(20);
    chk("held_norepeat", 8'(evt_valid), 8'h0);
    chk("held_nodrop",   8'(drop_count), 8'h0);
    btn_n = 4'hF;
    tick(12);
    chk("clean_release", 8'(btn_level), 8'h0);

    // Bounce on TR shorter than the debounce window.
    for (int i = 0; i < 10; i++) begin
      btn_n[1] = ~btn_n[1];
      tick(3);
      chk("bounce_level", 8'(btn_level), 8'h0);
    end
    tick(12);
    chk("bounce_valid", 8'(evt_valid), 8'h0);
    chk("bounce_level_end", 8'(btn_level), 8'h0);

    // TR and BR together: one event, TR wins, multi flagged.
    btn_n = 4'b0101;
    tick(11);
    chk("multi_valid", 8'(evt_valid), 8'h1);
    chk("multi_zone",  8'(evt_zone),  8'h1);
    chk("multi_flag",  8'(evt_multi), 8'h1);
    handshake("multi_ack");
    btn_n = 4'hF;
    tick(12);
    chk("multi_drop", 8'(drop_count), 8'h0);

    // Busy: 20 more TL presses while the first is pending.
    btn_n = 4'b1110;
    tick(11);
    chk("busy_valid", 8'(evt_valid), 8'h1);
    chk("busy_zone0", 8'(evt_zone),  8'h0);
    for (int i = 0; i < 20; i++) begin
      btn_n[0] = 1'b1;
      tick(12);
      btn_n[0] = 1'b0;
      tick(12);
      if (i == 0)  chk("busy_drop1",  8'(drop_count), 8'd1);
      if (i == 13) chk("busy_drop14", 8'(drop_count), 8'd14);
      if (i == 14) chk("busy_drop15", 8'(drop_count), 8'd15);
    end
    chk("busy_sat",   8'(drop_count), 8'd15);
    chk("busy_zone",  8'(evt_zone),   8'h0);
    chk("busy_still", 8'(evt_valid),  8'h1);
    handshake("busy_ack");
    btn_n = 4'hF;
    tick(12);
    chk("busy_sat_after", 8'(drop_count), 8'd15);

    // Reset while pending, with TL still held.
    btn_n = 4'b1110;
    tick(11);
    chk("rstmid_valid", 8'(evt_valid), 8'h1);
    reset = 1'b1;
    tick(1);
    chk("rstmid_evt",   8'(evt_valid),  8'h0);
    chk("rstmid_drop",  8'(drop_count), 8'h0);
    chk("rstmid_level", 8'(btn_level),  8'h0);
    reset = 1'b0;
    btn_n = 4'hF;
    tick(15);
    chk("rstmid_quiet", 8'(evt_valid), 8'h0);
    btn_n = 4'b0111;
    tick(11);
    chk("rstmid_new_valid", 8'(evt_valid), 8'h1);
    chk("rstmid_new_zone",  8'(evt_zone),  8'h3);
    chk("rstmid_new_multi", 8'(evt_multi), 8'h0);
    handshake("rstmid_ack");
    btn_n = 4'hF;
    tick(12);

    // Ack stuck high out of reset.
    reset   = 1'b1;
    evt_ack = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(3);
    btn_n = 4'b1110;
    tick(11);
    chk("stuck_valid", 8'(evt_valid),  8'h0);
    chk("stuck_drop",  8'(drop_count), 8'd1);
    btn_n = 4'hF;
    tick(12);
    evt_ack = 1'b0;
    tick(3);
    btn_n = 4'b1110;
    tick(11);
    chk("stuck_rec_valid", 8'(evt_valid),  8'h1);
    chk("stuck_rec_zone",  8'(evt_zone),   8'h0);
    chk("stuck_rec_drop",  8'(drop_count), 8'd1);
    handshake("stuck_ack");
    btn_n = 4'hF;
    tick(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
